// File: rtl/inst_encoder.sv
// Instruction word encoder: turns field descriptors into canonical 32-bit words with
// sequential addresses, optionally following each control-transfer word with a nop.
module inst_encoder #(
  parameter logic [31:0] BASE_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        auto_nop,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [5:0]  in_code,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ir,
  output logic [31:0] out_pc,
  output logic        out_err,
  output logic        err_sticky
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StInst  = 2'd1;
  localparam logic [1:0] StNop   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] ir_q, pc_q;
  logic        ctrl_q, err_q, sticky_q;

  logic [31:0] enc_ir;
  logic        enc_ok, enc_ctrl;
  logic [4:0]  f_rs, f_rt, f_rd, f_sh;
  logic        accept, acc_ok, out_fire;

  // Decode, validate and canonicalise the incoming descriptor.
  always_comb begin
    enc_ok   = 1'b0;
    enc_ctrl = 1'b0;
    enc_ir   = '0;
    f_rs     = in_rs;
    f_rt     = in_rt;
    f_rd     = in_rd;
    f_sh     = in_shamt;
    unique case (in_fmt)
      2'd0: begin
        case (in_code)
          6'h21, 6'h23, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h24,
          6'h25, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09: enc_ok = 1'b1;
          default: enc_ok = 1'b0;
        endcase
        if (in_code == 6'h00 || in_code == 6'h02 || in_code == 6'h03) begin
          f_rs = '0;
        end else begin
          f_sh = '0;
        end
        if (in_code == 6'h08) begin
          f_rt = '0;
          f_rd = '0;
        end
        if (in_code == 6'h09) f_rt = '0;
        enc_ctrl = (in_code == 6'h08) || (in_code == 6'h09);
        enc_ir   = {6'h00, f_rs, f_rt, f_rd, f_sh, in_code};
      end
      2'd1: begin
        case (in_code)
          6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21,
          6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h04, 6'h05, 6'h06, 6'h07: enc_ok = 1'b1;
          default: enc_ok = 1'b0;
        endcase
        if (in_code == 6'h0F) f_rs = '0;
        if (in_code == 6'h06 || in_code == 6'h07) f_rt = '0;
        enc_ctrl = (in_code >= 6'h04) && (in_code <= 6'h07);
        enc_ir   = {in_code, f_rs, f_rt, in_imm};
      end
      2'd2: begin
        enc_ok   = (in_code == 6'h00) || (in_code == 6'h01);
        enc_ctrl = 1'b1;
        enc_ir   = {6'h01, in_rs, in_code[4:0], in_imm};
      end
      2'd3: begin
        enc_ok   = (in_code == 6'h02) || (in_code == 6'h03);
        enc_ctrl = 1'b1;
        enc_ir   = {in_code, in_addr};
      end
      default: enc_ok = 1'b0;
    endcase
  end

  assign out_valid = (state_q != StEmpty);
  assign out_fire  = out_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign acc_ok    = accept && enc_ok;

  // auto_nop is looked at live, so the decision is made when the branch word fires.
  always_comb begin
    in_ready = 1'b0;
    state_d  = state_q;
    case (state_q)
      StEmpty: begin
        in_ready = 1'b1;
        if (acc_ok) state_d = StInst;
      end
      StInst: begin
        in_ready = out_ready && !(ctrl_q && auto_nop);
        if (out_fire) begin
          if (ctrl_q && auto_nop) state_d = StNop;
          else if (acc_ok)        state_d = StInst;
          else                    state_d = StEmpty;
        end
      end
      StNop: begin
        in_ready = out_ready;
        if (out_fire) state_d = acc_ok ? StInst : StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StEmpty;
      ir_q     <= '0;
      ctrl_q   <= 1'b0;
      pc_q     <= BASE_PC;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc_ok) begin
        ir_q   <= enc_ir;
        ctrl_q <= enc_ctrl;
      end
      if (out_fire) pc_q <= pc_q + 32'd4;
      err_q    <= accept && !enc_ok;
      sticky_q <= sticky_q || (accept && !enc_ok);
    end
  end

  assign out_ir     = (state_q == StNop) ? 32'h0 : ir_q;
  assign out_pc     = pc_q;
  assign out_err    = err_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed vector table, hand sequences for handshake corners,
// and a randomized run against a queue-based model of the emitted word stream.
module tb_inst_encoder;

  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam logic [5:0] R_LIST [16] = '{6'h21, 6'h23, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03,
    6'h24, 6'h25, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09};
  localparam logic [5:0] I_LIST [20] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
    6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h04, 6'h05, 6'h06, 6'h07};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        auto_nop = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_fmt = '0;
  logic [5:0]  in_code = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_ir, out_pc;
  logic        out_err, err_sticky;

  int total = 0;
  int passed = 0;

  inst_encoder #(.BASE_PC(BASE)) dut (
    .clk(clk), .reset(reset), .auto_nop(auto_nop), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_code(in_code), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_addr(in_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc), .out_err(out_err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  code;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] addr;
    bit          ok;
    logic [31:0] ir;
  } vec_t;

  typedef struct packed {
    logic [31:0] ir;
    logic        ctrl;
  } ent_t;

  vec_t vecs[13];
  ent_t q[$];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drive(input logic [1:0] fmt, input logic [5:0] code, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                       input logic [15:0] imm, input logic [25:0] addr);
    in_valid = 1'b1;
    in_fmt = fmt; in_code = code; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_addr = addr;
  endtask

  // Reference encoder written from the instruction-set rules.
  function automatic void ref_enc(input logic [1:0] fmt, input logic [5:0] code,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [4:0] sh,
                                  input logic [15:0] imm, input logic [25:0] addr,
                                  output bit ok, output bit ctrl, output logic [31:0] w);
    logic [4:0] a, b, c, d;
    bit shift_op;
    ok = 0; ctrl = 0; w = '0;
    a = rs; b = rt; c = rd; d = sh;
    case (fmt)
      2'd0: begin
        for (int k = 0; k < 16; k++) if (R_LIST[k] == code) ok = 1;
        shift_op = (code == 6'h00 || code == 6'h02 || code == 6'h03);
        if (shift_op) a = 5'd0;
        else d = 5'd0;
        if (code == 6'h08) begin b = 5'd0; c = 5'd0; end
        if (code == 6'h09) b = 5'd0;
        ctrl = (code == 6'h08 || code == 6'h09);
        w = {6'd0, a, b, c, d, code};
      end
      2'd1: begin
        for (int k = 0; k < 20; k++) if (I_LIST[k] == code) ok = 1;
        if (code == 6'h0F) a = 5'd0;
        if (code == 6'h06 || code == 6'h07) b = 5'd0;
        ctrl = (code >= 6'h04 && code <= 6'h07);
        w = {code, a, b, imm};
      end
      2'd2: begin
        ok = (code <= 6'h01);
        ctrl = 1;
        w = {6'h01, rs, code[4:0], imm};
      end
      default: begin
        ok = (code == 6'h02 || code == 6'h03);
        ctrl = 1;
        w = {code, addr};
      end
    endcase
  endfunction

  function automatic logic [5:0] pick(input logic [1:0] fmt);
    if ($urandom_range(3) == 0) return 6'($urandom);
    case (fmt)
      2'd0:    return R_LIST[$urandom_range(15)];
      2'd1:    return I_LIST[$urandom_range(19)];
      2'd2:    return 6'($urandom_range(1));
      default: return 6'($urandom_range(3, 2));
    endcase
  endfunction

  initial begin
    logic [31:0] epc, mpc;
    bit ok, ctrl, exp_v, exp_rdy, fire, acc, err_pend, sticky_m;
    logic [31:0] w;
    ent_t f, e;

    vecs[0]  = '{2'd0, 6'h21, 5'd1,  5'd2, 5'd3,  5'd5, 16'h0,    26'h0,       1'b1, 32'h0022_1821};
    vecs[1]  = '{2'd1, 6'h0F, 5'd7,  5'd4, 5'd9,  5'd1, 16'h1234, 26'h0,       1'b1, 32'h3C04_1234};
    vecs[2]  = '{2'd0, 6'h00, 5'd9,  5'd2, 5'd3,  5'd5, 16'h0,    26'h0,       1'b1, 32'h0002_1940};
    vecs[3]  = '{2'd0, 6'h08, 5'd31, 5'd5, 5'd6,  5'd7, 16'h0,    26'h0,       1'b1, 32'h03E0_0008};
    vecs[4]  = '{2'd0, 6'h09, 5'd4,  5'd5, 5'd31, 5'd3, 16'h0,    26'h0,       1'b1, 32'h0080_F809};
    vecs[5]  = '{2'd1, 6'h07, 5'd3,  5'd9, 5'd0,  5'd0, 16'h0010, 26'h0,       1'b1, 32'h1C60_0010};
    vecs[6]  = '{2'd2, 6'h01, 5'd2,  5'd7, 5'd0,  5'd0, 16'hFFFE, 26'h0,       1'b1, 32'h0441_FFFE};
    vecs[7]  = '{2'd3, 6'h03, 5'd0,  5'd0, 5'd0,  5'd0, 16'h0,    26'h3FF_FFFF, 1'b1, 32'h0FFF_FFFF};
    vecs[8]  = '{2'd1, 6'h3F, 5'd1,  5'd1, 5'd1,  5'd1, 16'h1,    26'h0,       1'b0, 32'h0};
    vecs[9]  = '{2'd0, 6'h01, 5'd1,  5'd1, 5'd1,  5'd1, 16'h1,    26'h0,       1'b0, 32'h0};
    vecs[10] = '{2'd2, 6'h02, 5'd1,  5'd1, 5'd1,  5'd1, 16'h1,    26'h0,       1'b0, 32'h0};
    vecs[11] = '{2'd3, 6'h04, 5'd1,  5'd1, 5'd1,  5'd1, 16'h1,    26'h1,       1'b0, 32'h0};
    vecs[12] = '{2'd1, 6'h23, 5'd29, 5'd8, 5'd0,  5'd0, 16'h8000, 26'h0,       1'b1, 32'h8FA8_8000};

    // Reset state
    do_reset();
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk32("rst_out_pc", out_pc, BASE);
    chk32("rst_out_ir", out_ir, 32'h0);
    chk1("rst_out_err", out_err, 1'b0);
    chk1("rst_err_sticky", err_sticky, 1'b0);

    // Back-to-back words
    out_ready = 1'b1; auto_nop = 1'b0;
    drive(2'd1, 6'h0F, 5'd7, 5'd4, 5'd0, 5'd0, 16'h1234, 26'h0);
    tick();
    drive(2'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0);
    #1;
    chk1("b2b_valid0", out_valid, 1'b1);
    chk32("b2b_ir0", out_ir, 32'h3C04_1234);
    chk32("b2b_pc0", out_pc, 32'h0000_3000);
    chk1("b2b_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk1("b2b_valid1", out_valid, 1'b1);
    chk32("b2b_ir1", out_ir, 32'h0022_1821);
    chk32("b2b_pc1", out_pc, 32'h0000_3004);
    tick();
    chk1("b2b_drain", out_valid, 1'b0);
    chk32("b2b_pc2", out_pc, 32'h0000_3008);

    // Stall holds the word
    do_reset();
    out_ready = 1'b0;
    drive(2'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0);
    tick();
    drive(2'd3, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF);
    for (int i = 0; i < 3; i++) begin
      chk32("stall_ir", out_ir, 32'h0022_1821);
      chk32("stall_pc", out_pc, 32'h0000_3000);
      chk1("stall_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk1("stall_release_rdy", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk32("stall_next_ir", out_ir, 32'h0FFF_FFFF);
    chk32("stall_next_pc", out_pc, 32'h0000_3004);

    // Branch with delay-slot nop, then reset while the nop is pending
    do_reset();
    auto_nop = 1'b1; out_ready = 1'b1;
    drive(2'd1, 6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
    tick();
    drive(2'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0);
    #1;
    chk32("br_ir", out_ir, 32'h1022_FFFF);
    chk32("br_pc", out_pc, 32'h0000_3000);
    chk1("br_in_ready", in_ready, 1'b0);
    tick();
    chk1("nop_valid", out_valid, 1'b1);
    chk32("nop_ir", out_ir, 32'h0);
    chk32("nop_pc", out_pc, 32'h0000_3004);
    chk1("nop_in_ready", in_ready, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk32("nop_hold_ir", out_ir, 32'h0);
    chk1("nop_hold_rdy", in_ready, 1'b0);
    do_reset();
    chk1("nop_rst_valid", out_valid, 1'b0);
    chk32("nop_rst_pc", out_pc, BASE);
    chk1("nop_rst_rdy", in_ready, 1'b1);

    // auto_nop is taken from the firing cycle, not the accept cycle
    auto_nop = 1'b0; out_ready = 1'b0;
    drive(2'd3, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    tick();
    in_valid = 1'b0;
    tick();
    auto_nop = 1'b1; out_ready = 1'b1;
    #1;
    chk1("late_nop_rdy", in_ready, 1'b0);
    tick();
    chk1("late_nop_valid", out_valid, 1'b1);
    chk32("late_nop_ir", out_ir, 32'h0);
    tick();
    chk1("late_nop_done", out_valid, 1'b0);
    out_ready = 1'b0;
    drive(2'd3, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    tick();
    in_valid = 1'b0; auto_nop = 1'b0; out_ready = 1'b1;
    tick();
    chk1("no_nop_valid", out_valid, 1'b0);
    chk32("no_nop_pc", out_pc, 32'h0000_300C);

    // Unsupported descriptor
    do_reset();
    out_ready = 1'b1;
    drive(2'd1, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5, 26'h0);
    tick();
    in_valid = 1'b0;
    chk1("err_pulse", out_err, 1'b1);
    chk1("err_sticky", err_sticky, 1'b1);
    chk1("err_no_valid", out_valid, 1'b0);
    chk32("err_pc", out_pc, BASE);
    tick();
    chk1("err_pulse_end", out_err, 1'b0);
    chk1("err_sticky_hold", err_sticky, 1'b1);

    // Vector table
    do_reset();
    out_ready = 1'b1; auto_nop = 1'b0;
    epc = BASE;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].fmt, vecs[i].code, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
            vecs[i].imm, vecs[i].addr);
      tick();
      in_valid = 1'b0;
      chk1($sformatf("vec%0d_valid", i), out_valid, vecs[i].ok);
      chk1($sformatf("vec%0d_err", i), out_err, !vecs[i].ok);
      if (vecs[i].ok) begin
        chk32($sformatf("vec%0d_ir", i), out_ir, vecs[i].ir);
        chk32($sformatf("vec%0d_pc", i), out_pc, epc);
        epc += 32'd4;
      end
      tick();
    end
    chk1("vec_sticky", err_sticky, 1'b1);

    // Randomized run against the stream model
    do_reset();
    q.delete();
    mpc = BASE; err_pend = 0; sticky_m = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid = 1'($urandom_range(1));
      in_fmt = 2'($urandom);
      in_code = pick(in_fmt);
      in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
      in_shamt = 5'($urandom); in_imm = 16'($urandom); in_addr = 26'($urandom);
      out_ready = ($urandom_range(9) < 7);
      auto_nop = 1'($urandom_range(1));
      #1;
      exp_v = (q.size() != 0);
      exp_rdy = 1'b1;
      if (exp_v) exp_rdy = out_ready && !(q[0].ctrl && auto_nop);
      chk1("rnd_valid", out_valid, exp_v);
      chk1("rnd_in_ready", in_ready, exp_rdy);
      chk1("rnd_err", out_err, err_pend);
      chk1("rnd_sticky", err_sticky, sticky_m);
      chk32("rnd_pc", out_pc, mpc);
      if (exp_v) chk32("rnd_ir", out_ir, q[0].ir);
      ref_enc(in_fmt, in_code, in_rs, in_rt, in_rd, in_shamt, in_imm, in_addr, ok, ctrl, w);
      fire = exp_v && out_ready;
      acc = in_valid && exp_rdy;
      tick();
      if (fire) begin
        f = q.pop_front();
        mpc += 32'd4;
        if (f.ctrl && auto_nop) begin
          e.ir = 32'h0; e.ctrl = 1'b0;
          q.push_front(e);
        end
      end
      if (acc && ok) begin
        e.ir = w; e.ctrl = ctrl;
        q.push_back(e);
      end
      err_pend = acc && !ok;
      sticky_m = sticky_m || err_pend;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter: BASE_PC, 32'h0000_3000, address tagged on first emitted word after reset.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
REQ-004 SHALL have port: auto_nop  input  1  1 = insert delay-slot nop after every control-transfer word.
REQ-005 SHALL have port: in_valid  input  1  descriptor present.
REQ-006 SHALL have port: in_ready  output  1  descriptor accepted when in_valid && in_ready.
REQ-007 SHALL have port: in_fmt  input  2  0=R (op 0, funct=code), 1=I (op=code), 2=REGIMM (op 1, rt=code[4:0]), 3=J (op=code).
REQ-008 SHALL have port: in_code  input  6  funct/opcode/rt selector per in_fmt.
REQ-009 SHALL have ports: in_rs, in_rt, in_rd, in_shamt  input  5 each  register/shift fields.
REQ-010 SHALL have ports: in_imm  input  16; in_addr  input  26  immediate and jump target.
REQ-011 SHALL have ports: out_valid  output  1; out_ready  input  1  output handshake.
REQ-012 SHALL have ports: out_ir  output  32  encoded word; out_pc  output  32  its address.
REQ-013 SHALL have ports: out_err  output  1  one-cycle pulse on rejected descriptor; err_sticky  output  1  latched error.

Function
REQ-014 SHALL accept as supported only: R funct {21,23,2A,2B,00,02,03,24,25,26,27,04,06,07,08,09}h; I op {08,09,0A,0B,0C,0D,0E,0F,20,21,23,24,25,28,29,2B,04,05,06,07}h; REGIMM rt {00,01}h; J op {02,03}h.
REQ-015 SHALL encode R as {0,rs,rt,rd,shamt,funct}, I as {op,rs,rt,imm}, REGIMM as {01h,rs,code[4:0],imm}, J as {op,addr}.
REQ-016 SHALL canonicalise: shamt=0 for R except funct 00/02/03; rs=0 for funct 00/02/03 and op 0F; rt=rd=shamt=0 for funct 08; rt=shamt=0 for funct 09; rt=0 for op 06/07.
REQ-017 SHALL classify as control-transfer: funct 08/09, REGIMM, I op 04-07, J op 02/03.
REQ-018 SHALL implement FSM states EMPTY, INST, NOP.
REQ-019 EMPTY: out_valid=0, in_ready=1; supported accept -> INST with encoded word registered (1-cycle latency).
REQ-020 INST: out_valid=1; in_ready = out_ready && !(ctrl-transfer && auto_nop).
REQ-021 INST on out fire: ctrl-transfer && auto_nop -> NOP; else same-cycle accept -> INST with new word; else -> EMPTY.
REQ-022 NOP: out_valid=1, out_ir=32'h0; in_ready=out_ready; on out fire -> INST if accept else EMPTY.
REQ-023 auto_nop SHALL be sampled on the cycle the branch word fires, not at acceptance.
REQ-024 out_pc SHALL advance by 4 on every out fire (including nops), wrapping 32'hFFFF_FFFC -> 0.
REQ-025 out_ir/out_pc SHALL hold stable while out_valid && !out_ready.
REQ-026 Unsupported accepted descriptor: consumed, not emitted, out_err=1 next cycle for one cycle, err_sticky set, state/out_pc unchanged.
REQ-027 in_* fields SHALL be ignored when in_valid=0.

Reset
REQ-028 On reset: state EMPTY, out_valid=0, in_ready=1, out_ir=0, out_pc=BASE_PC, out_err=0, err_sticky=0; overrides any concurrent handshake.
REQ-029 err_sticky SHALL clear only by reset.

Verification
REQ-030 Reset release -> out_valid=0, in_ready=1, out_pc=32'h3000, err_sticky=0.
REQ-031 R code 21h rs=1 rt=2 rd=3 shamt=5, out_ready=1 -> next cycle out_ir=32'h0022_1821, out_pc=32'h3000.
REQ-032 I code 0Fh rs=7 rt=4 imm=1234h -> out_ir=32'h3C04_1234; back-to-back second word at out_pc=32'h3004.
REQ-033 auto_nop=1, I code 04h rs=1 rt=2 imm=FFFFh -> 32'h1022_FFFF @3000 (in_ready=0 that cycle), then 32'h0 @3004.
REQ-034 I code 3Fh -> out_err pulse, err_sticky=1, no out_valid, out_pc unchanged.
REQ-035 out_ready=0 three cycles with INST held -> out_ir/out_pc constant, in_ready=0; reset while in NOP -> EMPTY, out_pc=32'h3000.
